// File: rtl/jk_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jk_seq_driver
// Brief    : Converts a stream of requested flop-bank states into registered
//            J/K excitation for an external bank of JK flip-flops. It tracks
//            the bank state in a shadow register and checks the fed-back q
//            outputs two edges after each apply.
// Options  : define JK_TOGGLE_MODE_EN to drive every state change with
//            J=K=1 (toggle) instead of set/reset excitation.
// Revision : 1.0 - initial release
// ============================================================================
module jk_seq_driver #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    // FIFO pointers carry one extra wrap bit so full and empty are distinct.
    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    C_PTR_ONE  = (AW+1)'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    // SYNC loads the shadow from the bank once after reset; RUN streams targets.
    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Target FIFO storage and pointers.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_in_run;
    logic [WIDTH-1:0] w_head;

    // Apply stage: registered excitation plus the shadow of the bank state.
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_apply_v;
    logic [WIDTH-1:0] w_j_nxt;
    logic [WIDTH-1:0] w_k_nxt;

    // Check stage: shadow delayed to line up with the bank's captured state.
    logic             r_chk_v;
    logic [WIDTH-1:0] r_shadow_d;
    logic             w_mismatch;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    // ------------------------------------------------------------------
    // FIFO status and handshake
    // ------------------------------------------------------------------
    assign w_in_run  = (r_state == ST_RUN);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign tgt_ready = w_in_run && !w_full;
    assign w_push    = tgt_valid && tgt_ready;
    // The head is popped every RUN cycle it exists, so throughput is one per cycle.
    assign w_pop     = w_in_run && !w_empty;
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

    // State register for the SYNC/RUN sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: SYNC lasts exactly one cycle, RUN is terminal.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    // FIFO storage write; contents need no reset since the pointers are flushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= tgt_data;
        end
    end

    // FIFO pointer update; push and pop in one cycle both advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Excitation: inverse of the JK characteristic, don't-cares forced to 0
    // ------------------------------------------------------------------
    // Derive J/K for moving the bank from the shadow state to the FIFO head.
    always_comb begin
        w_j_nxt = '0;
        w_k_nxt = '0;
`ifdef JK_TOGGLE_MODE_EN
        // Any bit that changes is toggled; bits that hold get J=K=0.
        w_j_nxt = r_shadow ^ w_head;
        w_k_nxt = r_shadow ^ w_head;
`else
        // 0->1 sets, 1->0 resets, holds get J=K=0.
        w_j_nxt = ~r_shadow & w_head;
        w_k_nxt = r_shadow & ~w_head;
`endif
    end

    // Apply stage: register excitation on a pop, otherwise drive hold (J=K=0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_apply_v <= 1'b0;
        end else if (!w_in_run) begin
            // Adopt whatever state the bank is actually in before streaming.
            r_shadow  <= q_fb;
            r_j       <= '0;
            r_k       <= '0;
            r_apply_v <= 1'b0;
        end else if (w_pop) begin
            r_shadow  <= w_head;
            r_j       <= w_j_nxt;
            r_k       <= w_k_nxt;
            r_apply_v <= 1'b1;
        end else begin
            r_j       <= '0;
            r_k       <= '0;
            r_apply_v <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Check pipeline
    // ------------------------------------------------------------------
    // The bank captures J/K one edge after the apply; q_fb is then valid a
    // full cycle, so the compare happens one edge later still.
    assign w_mismatch = r_chk_v && (q_fb != r_shadow_d);

    // Align the expected state with the edge on which the bank captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_v    <= 1'b0;
            r_shadow_d <= '0;
        end else begin
            r_chk_v    <= r_apply_v;
            r_shadow_d <= r_shadow;
        end
    end

    // Flag a mismatch as a one-cycle pulse and keep a saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_mismatch;
            if (w_mismatch && (r_err_cnt != C_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + C_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign j       = r_j;
    assign k       = r_k;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;
    assign busy    = !w_empty || r_apply_v || r_chk_v;

endmodule
`default_nettype wire

// File: tb/tb_jk_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jk_seq_driver
// Brief    : Self-checking bench for jk_seq_driver. A JK flop bank model
//            closes the loop; a queue-based reference model predicts every
//            output each cycle; directed steps pin literal values.
// Options  : honours JK_TOGGLE_MODE_EN for the excitation rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_seq_driver;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] tgt_data = '0;
    logic             tgt_valid = 1'b0;
    logic             tgt_ready;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_fb;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    jk_seq_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_data  (tgt_data),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .busy      (busy),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // External JK flop bank with fault injection on its feedback
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_bank = '0;
    logic             bank_init_en = 1'b1;
    logic [WIDTH-1:0] bank_init_val = '0;
    logic             stuck_en = 1'b0;
    logic [WIDTH-1:0] stuck_val = '0;
    logic [WIDTH-1:0] flip_mask = '0;

    assign q_fb = stuck_en ? stuck_val : (q_bank ^ flip_mask);

    // JK characteristic: Q+ = J.~Q + ~K.Q
    always @(posedge clk) begin
        if (bank_init_en) q_bank <= bank_init_val;
        else              q_bank <= (j & ~q_bank) | (~k & q_bank);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: target queue, scheduled checks, bank shadow
    // ------------------------------------------------------------------
    typedef struct {
        int               due;
        logic [WIDTH-1:0] exp;
    } chk_t;

    int               cyc = 0;
    bit               m_on = 0;
    bit               m_sync = 1;
    logic [WIDTH-1:0] m_fifo[$];
    chk_t             m_chk[$];
    logic [WIDTH-1:0] m_shadow = '0;
    logic [WIDTH-1:0] m_j = '0;
    logic [WIDTH-1:0] m_k = '0;
    bit               m_err = 0;
    int               m_cnt = 0;

    // Excitation table applied bit by bit from (current, target).
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] jj;
        logic [WIDTH-1:0] kk;
        jj = '0;
        kk = '0;
        for (int b = 0; b < WIDTH; b++) begin
            case ({s[b], t[b]})
`ifdef JK_TOGGLE_MODE_EN
                2'b01:   begin jj[b] = 1'b1; kk[b] = 1'b1; end
                2'b10:   begin jj[b] = 1'b1; kk[b] = 1'b1; end
`else
                2'b01:   begin jj[b] = 1'b1; kk[b] = 1'b0; end
                2'b10:   begin jj[b] = 1'b0; kk[b] = 1'b1; end
`endif
                default: begin jj[b] = 1'b0; kk[b] = 1'b0; end
            endcase
        end
        return {jj, kk};
    endfunction

    // Advance the model on each rising edge using pre-edge inputs.
    always @(posedge clk) begin
        logic [WIDTH-1:0] qs;
        logic [WIDTH-1:0] t;
        bit rdy;
        bit psh;
        cyc++;
        qs = q_fb;
        if (rst) begin
            m_on = 1;
            m_sync = 1;
            m_fifo.delete();
            m_chk.delete();
            m_shadow = '0;
            m_j = '0;
            m_k = '0;
            m_err = 0;
            m_cnt = 0;
        end else if (m_on) begin
            rdy = !m_sync && (m_fifo.size() < DEPTH);
            psh = tgt_valid && rdy;
            m_err = 0;
            if (m_chk.size() > 0 && m_chk[0].due == cyc) begin
                m_err = (qs !== m_chk[0].exp);
                if (m_err && m_cnt < CNT_MAX) m_cnt++;
                void'(m_chk.pop_front());
            end
            if (m_sync) begin
                m_shadow = qs;
                m_sync = 0;
                m_j = '0;
                m_k = '0;
            end else if (m_fifo.size() > 0) begin
                t = m_fifo.pop_front();
                {m_j, m_k} = excite(m_shadow, t);
                m_shadow = t;
                m_chk.push_back('{cyc + 2, t});
            end else begin
                m_j = '0;
                m_k = '0;
            end
            if (psh) m_fifo.push_back(tgt_data);
        end
    end

    // Compare every DUT output with the model once per cycle.
    always @(negedge clk) begin
        if (m_on) begin
            chk("m_tgt_ready", tgt_ready, !m_sync && (m_fifo.size() < DEPTH));
            chk("m_j", j, m_j);
            chk("m_k", k, m_k);
            chk("m_busy", busy, (m_fifo.size() > 0) || (m_chk.size() > 0));
            chk("m_err", err, m_err);
            chk("m_err_cnt", err_cnt, m_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with directed literal checks
    // ------------------------------------------------------------------
    task automatic send(input logic [WIDTH-1:0] d);
        int n;
        tgt_data = d;
        tgt_valid = 1'b1;
        n = 0;
        while (!tgt_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", tgt_ready, 1'b1);
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] cnt_before;
        // Reset with the bank held at 0000.
        rst = 1'b1;
        bank_init_en = 1'b1;
        bank_init_val = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_j", j, 4'h0);
        chk("rst_k", k, 4'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_ready", tgt_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        bank_init_en = 1'b0;
        @(negedge clk);
        chk("sync_ready", tgt_ready, 1'b1);

        // 0000 -> 0101
        send(4'b0101);
        @(negedge clk);
`ifdef JK_TOGGLE_MODE_EN
        chk("t1_j", j, 4'b0101);
        chk("t1_k", k, 4'b0101);
`else
        chk("t1_j", j, 4'b0101);
        chk("t1_k", k, 4'b0000);
`endif
        repeat (2) @(negedge clk);
        chk("t1_err", err, 1'b0);

        // 0101 -> 1010
        send(4'b1010);
        @(negedge clk);
`ifdef JK_TOGGLE_MODE_EN
        chk("t2_j", j, 4'b1111);
        chk("t2_k", k, 4'b1111);
`else
        chk("t2_j", j, 4'b1010);
        chk("t2_k", k, 4'b0101);
`endif
        @(negedge clk);
        chk("t2_q_fb", q_fb, 4'b1010);
        @(negedge clk);
        chk("t2_err", err, 1'b0);

        // Five back-to-back targets; busy drops two edges after the last pop.
        tgt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int n;
            tgt_data = 4'($urandom_range(0, 15));
            n = 0;
            while (!tgt_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        @(negedge clk);
        chk("burst_busy1", busy, 1'b1);
        @(negedge clk);
        chk("burst_busy2", busy, 1'b1);
        @(negedge clk);
        chk("burst_busy3", busy, 1'b0);

        // Feedback stuck at 0000 while pushing 1111.
        cnt_before = 4'(err_cnt);
        stuck_en = 1'b1;
        stuck_val = 4'b0000;
        send(4'b1111);
        repeat (2) @(negedge clk);
        chk("stuck_err_pre", err, 1'b0);
        @(negedge clk);
        chk("stuck_err", err, 1'b1);
        chk("stuck_cnt", err_cnt, 8'(cnt_before) + 8'd1);
        @(negedge clk);
        chk("stuck_err_pulse", err, 1'b0);

        // Keep failing until the counter saturates.
        tgt_data = 4'b1111;
        tgt_valid = 1'b1;
        repeat (300) @(negedge clk);
        tgt_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("sat_cnt", err_cnt, 8'd255);
        stuck_en = 1'b0;

        // Reset in the middle of a stream; bank sits at 0110.
        tgt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tgt_data = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        rst = 1'b1;
        bank_init_en = 1'b1;
        bank_init_val = 4'b0110;
        @(negedge clk);
        chk("mid_rst_j", j, 4'h0);
        chk("mid_rst_k", k, 4'h0);
        chk("mid_rst_ready", tgt_ready, 1'b0);
        chk("mid_rst_cnt", err_cnt, 8'd0);
        rst = 1'b0;
        bank_init_en = 1'b0;
        tgt_valid = 1'b0;
        @(negedge clk);
        chk("mid_sync_ready", tgt_ready, 1'b1);
        send(4'b1001);
        @(negedge clk);
`ifdef JK_TOGGLE_MODE_EN
        chk("mid_j", j, 4'b1111);
        chk("mid_k", k, 4'b1111);
`else
        chk("mid_j", j, 4'b1001);
        chk("mid_k", k, 4'b0110);
`endif
        repeat (2) @(negedge clk);
        chk("mid_err", err, 1'b0);

        // From 0000: push 0011 then 0000 back to back.
        rst = 1'b1;
        bank_init_en = 1'b1;
        bank_init_val = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        bank_init_en = 1'b0;
        @(negedge clk);
        tgt_data = 4'b0011;
        tgt_valid = 1'b1;
        @(negedge clk);
        tgt_data = 4'b0000;
        @(negedge clk);
        tgt_valid = 1'b0;
`ifdef JK_TOGGLE_MODE_EN
        chk("tg1_j", j, 4'b0011);
        chk("tg1_k", k, 4'b0011);
`else
        chk("tg1_j", j, 4'b0011);
        chk("tg1_k", k, 4'b0000);
`endif
        @(negedge clk);
`ifdef JK_TOGGLE_MODE_EN
        chk("tg2_j", j, 4'b0011);
        chk("tg2_k", k, 4'b0011);
`else
        chk("tg2_j", j, 4'b0000);
        chk("tg2_k", k, 4'b0011);
`endif
        repeat (3) @(negedge clk);
        chk("tg_err_cnt", err_cnt, 8'd0);

        // Randomised traffic with sporadic feedback faults and resets.
        for (int i = 0; i < 3000; i++) begin
            tgt_valid = ($urandom_range(0, 3) != 0);
            tgt_data = 4'($urandom_range(0, 15));
            flip_mask = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            rst = ($urandom_range(0, 199) == 0);
            bank_init_en = rst;
            bank_init_val = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        tgt_valid = 1'b0;
        flip_mask = '0;
        rst = 1'b0;
        bank_init_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
